// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle controller: opcodes, ALU codes,
// FSM state encodings and datapath mux select codes.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_WB_ALU   = 4'd4;
   localparam logic [3:0] S_MEM_ADDR = 4'd5;
   localparam logic [3:0] S_MEM_RD   = 4'd6;
   localparam logic [3:0] S_WB_MEM   = 4'd7;
   localparam logic [3:0] S_MEM_WR   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_ILLEGAL  = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [1:0] A_PC     = 2'd0;
   localparam logic [1:0] A_RS1    = 2'd1;
   localparam logic [1:0] A_OLD_PC = 2'd2;

   localparam logic [1:0] B_RS2  = 2'd0;
   localparam logic [1:0] B_FOUR = 2'd1;
   localparam logic [1:0] B_IMM  = 2'd2;

   localparam logic ADDR_PC      = 1'b0;
   localparam logic ADDR_ALU_OUT = 1'b1;
   localparam logic PC_SRC_ALU     = 1'b0;
   localparam logic PC_SRC_ALU_OUT = 1'b1;
   localparam logic WB_ALU_OUT = 1'b0;
   localparam logic WB_MDR     = 1'b1;

   // BEQ/BNE only; any other branch funct3 is treated as not taken.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic alu_zero);
      case (funct3)
         3'b000:  return alu_zero;
         3'b001:  return ~alu_zero;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. The trap signal exists only when
// ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       alu_zero;
   logic       mem_ready;

   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       ir_we;
   logic       pc_we;
   logic       pc_src;
   logic       reg_we;
   logic       wb_sel;
   logic [1:0] alu_a_sel;
   logic [1:0] alu_b_sel;
   logic [3:0] alu_ctrl;
   logic       instr_done;
   logic       mem_err;
`ifdef ILLEGAL_TRAP_EN
   logic       trap;
`endif

   modport master (
`ifdef ILLEGAL_TRAP_EN
      output trap,
`endif
      input  opcode, funct3, funct7_b5, alu_zero, mem_ready,
      output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
      output alu_a_sel, alu_b_sel, alu_ctrl, instr_done, mem_err
   );

   modport slave (
`ifdef ILLEGAL_TRAP_EN
      input  trap,
`endif
      output opcode, funct3, funct7_b5, alu_zero, mem_ready,
      input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
      input  alu_a_sel, alu_b_sel, alu_ctrl, instr_done, mem_err
   );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder for the R-type and I-type execute states.
module multicycle_ctrl_alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic       is_rtype_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_b5_i,
   output logic [3:0] alu_ctrl_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (funct3_i)
         // instr[30] of an I-type is immediate bit 10, so SUB only exists for R-type.
         3'b000:  alu_ctrl_o = (is_rtype_i && funct7_b5_i) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_ctrl_o = ALU_SLL;
         3'b010:  alu_ctrl_o = ALU_SLT;
         3'b011:  alu_ctrl_o = ALU_SLTU;
         3'b100:  alu_ctrl_o = ALU_XOR;
         3'b101:  alu_ctrl_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
         3'b110:  alu_ctrl_o = ALU_OR;
         default: alu_ctrl_o = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset core with a memory-wait watchdog.
// Optional feature: define ILLEGAL_TRAP_EN to halt in a sticky trap on illegal opcodes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255,
   parameter int unsigned CNT_W    = 8
) (
   input logic clk,
   input logic rst_n,
   multicycle_ctrl_if.master bus
);

   localparam bit               WD_EN     = (MAX_WAIT != 0);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WD_EN ? MAX_WAIT - 1 : 0);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [3:0]       dec_alu_ctrl;
   logic             mem_wait, wd_expire;

   logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel;
   logic       instr_done, mem_err;
   logic [1:0] alu_a_sel, alu_b_sel;
   logic [3:0] alu_ctrl;
`ifdef ILLEGAL_TRAP_EN
   logic       trap;
`endif

   multicycle_ctrl_alu_decoder u_alu_dec (
      .is_rtype_i  (state_q == S_EXEC_R),
      .funct3_i    (bus.funct3),
      .funct7_b5_i (bus.funct7_b5),
      .alu_ctrl_o  (dec_alu_ctrl)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = ADDR_PC;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_we     = 1'b0;
      wb_sel     = WB_ALU_OUT;
      alu_a_sel  = A_PC;
      alu_b_sel  = B_RS2;
      alu_ctrl   = ALU_ADD;
      instr_done = 1'b0;
      mem_err    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap       = 1'b0;
`endif

      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_b_sel = B_FOUR;
            if (bus.mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively form the branch target old_pc+imm into alu_out.
            alu_a_sel = A_OLD_PC;
            alu_b_sel = B_IMM;
            case (bus.opcode)
               OP_R:               state_d = S_EXEC_R;
               OP_I:               state_d = S_EXEC_I;
               OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
               OP_BRANCH:          state_d = S_BRANCH;
               default:            state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            alu_a_sel = A_RS1;
            alu_b_sel = B_RS2;
            alu_ctrl  = dec_alu_ctrl;
            state_d   = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_a_sel = A_RS1;
            alu_b_sel = B_IMM;
            alu_ctrl  = dec_alu_ctrl;
            state_d   = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_a_sel = A_RS1;
            alu_b_sel = B_IMM;
            state_d   = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            addr_sel = ADDR_ALU_OUT;
            if (bus.mem_ready) state_d = S_WB_MEM;
         end
         S_WB_MEM: begin
            reg_we     = 1'b1;
            wb_sel     = WB_MDR;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = ADDR_ALU_OUT;
            if (bus.mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_a_sel  = A_RS1;
            alu_b_sel  = B_RS2;
            alu_ctrl   = ALU_SUB;
            pc_src     = PC_SRC_ALU_OUT;
            pc_we      = branch_taken(bus.funct3, bus.alu_zero);
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            trap    = 1'b1;
            state_d = S_TRAP;
`else
            // PC was already advanced in FETCH, so retiring here skips the word.
            instr_done = 1'b1;
            state_d    = S_FETCH;
`endif
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: trap = 1'b1;
`endif
         default: state_d = S_FETCH;
      endcase

      // Abort wins over the hold in any memory state; ready in the same cycle wins over abort.
      mem_wait  = mem_req & ~bus.mem_ready;
      wd_expire = WD_EN && mem_wait && (wait_cnt_q == WAIT_LAST);
      if (wd_expire) begin
         mem_err = 1'b1;
         state_d = S_FETCH;
      end

      wait_cnt_d = '0;
      if (mem_wait && !wd_expire)
         wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // NOTE: outputs are gated by rst_n combinationally, since the reset state itself requests a fetch.
   assign bus.mem_req    = rst_n & mem_req;
   assign bus.mem_we     = rst_n & mem_we;
   assign bus.addr_sel   = rst_n & addr_sel;
   assign bus.ir_we      = rst_n & ir_we;
   assign bus.pc_we      = rst_n & pc_we;
   assign bus.pc_src     = rst_n & pc_src;
   assign bus.reg_we     = rst_n & reg_we;
   assign bus.wb_sel     = rst_n & wb_sel;
   assign bus.alu_a_sel  = rst_n ? alu_a_sel : 2'b00;
   assign bus.alu_b_sel  = rst_n ? alu_b_sel : 2'b00;
   assign bus.alu_ctrl   = rst_n ? alu_ctrl  : 4'b0000;
   assign bus.instr_done = rst_n & instr_done;
   assign bus.mem_err    = rst_n & mem_err;
`ifdef ILLEGAL_TRAP_EN
   assign bus.trap       = rst_n & trap;
`endif

endmodule
